// File: rtl/rectangle_pkg.sv
// RECTANGLE-128 key-schedule shared types, constants and helper functions.
// Latency: n/a (package, combinational helpers only).
// Backpressure: none; consumers own all handshaking.
package rectangle_pkg;

  localparam int ROUNDS = 25;
  localparam int NKEYS  = 26;

  localparam logic [4:0] RC_INIT = 5'h01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    GEN   = 2'd2,
    DONE  = 2'd3
  } ks_state_e;

  // 4-bit RECTANGLE S-box, applied column-wise across the four rows.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h6;
      4'h1: y = 4'h5;
      4'h2: y = 4'hC;
      4'h3: y = 4'hA;
      4'h4: y = 4'h1;
      4'h5: y = 4'hE;
      4'h6: y = 4'h7;
      4'h7: y = 4'h9;
      4'h8: y = 4'hB;
      4'h9: y = 4'h0;
      4'hA: y = 4'h3;
      4'hB: y = 4'hD;
      4'hC: y = 4'h8;
      4'hD: y = 4'hF;
      4'hE: y = 4'h4;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // 5-bit LFSR producing the round-constant sequence 01,02,04,09,12,...
  function automatic logic [4:0] rc_next(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

  // Round key is the low halfword of every row, Row3 in the top bits.
  function automatic logic [63:0] extract_key(input logic [127:0] st);
    return {st[111:96], st[79:64], st[47:32], st[15:0]};
  endfunction

endpackage

// File: rtl/rectangle128_ks_round.sv
// One RECTANGLE-128 key-schedule round: S-box on columns 0..7, Feistel row mix, RC injection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module rectangle128_ks_round
  import rectangle_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [4:0]   rc_i,
  output logic [127:0] state_o
);

  logic [31:0] row0, row1, row2, row3;
  logic [31:0] s0, s1, s2, s3;
  logic [31:0] row0_n, row2_n;

  assign row0 = state_i[31:0];
  assign row1 = state_i[63:32];
  assign row2 = state_i[95:64];
  assign row3 = state_i[127:96];

  // Only the eight low columns go through the S-box; the rest pass straight through.
  assign s0[31:8] = row0[31:8];
  assign s1[31:8] = row1[31:8];
  assign s2[31:8] = row2[31:8];
  assign s3[31:8] = row3[31:8];

  for (genvar j = 0; j < 8; j++) begin : g_col
    assign {s3[j], s2[j], s1[j], s0[j]} = sbox({row3[j], row2[j], row1[j], row0[j]});
  end

  // Generalised Feistel: Row0 and Row2 absorb a rotated copy of themselves.
  assign row0_n = ({s0[23:0], s0[31:24]} ^ s1) ^ {27'd0, rc_i};
  assign row2_n = {s2[15:0], s2[31:16]} ^ s3;

  assign state_o = {s0, row2_n, s2, row0_n};

endmodule

// File: rtl/rectangle128_skeygen.sv
// RECTANGLE-128 round-key generator: latches the master key and writes K0..K25 to a key RAM.
// Latency: flush pulse 1 cycle after start, writes on the next 26 cycles (last write 27 cycles after start).
// Backpressure: none; the RAM must accept one write per cycle, Enable drops mid-run are ignored.
module rectangle128_skeygen
  import rectangle_pkg::*;
(
  input  logic        Clk,
  input  logic        RstN,
  input  logic        Enable,
  input  logic [63:0] key0,
  input  logic [63:0] key1,
  output logic        flush_mem,
  output logic        WE_mem,
  output logic [4:0]  WAddr_mem,
  output logic [63:0] KeyIn_mem
);

  ks_state_e    state_q, state_d;
  logic [4:0]   round_counter, round_counter_d;
  logic [127:0] key_q, key_d;
  logic [4:0]   rc_q, rc_d;
  logic [127:0] key_round;

  rectangle128_ks_round u_round (
    .state_i (key_q),
    .rc_i    (rc_q),
    .state_o (key_round)
  );

  // State, key rows, round counter and RC register with async clear.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q       <= IDLE;
      round_counter <= 5'd0;
      key_q         <= 128'd0;
      rc_q          <= RC_INIT;
    end else begin
      state_q       <= state_d;
      round_counter <= round_counter_d;
      key_q         <= key_d;
      rc_q          <= rc_d;
    end
  end

  // Next-state logic and Moore output decode from registered state only.
  always_comb begin
    state_d         = state_q;
    round_counter_d = round_counter;
    key_d           = key_q;
    rc_d            = rc_q;
    flush_mem       = 1'b0;
    WE_mem          = 1'b0;
    WAddr_mem       = 5'd0;
    KeyIn_mem       = 64'd0;

    case (state_q)
      IDLE: begin
        if (Enable) begin
          key_d           = {key1, key0};
          round_counter_d = 5'd0;
          rc_d            = RC_INIT;
          state_d         = FLUSH;
        end
      end
      FLUSH: begin
        flush_mem = 1'b1;
        state_d   = GEN;
      end
      GEN: begin
        WE_mem    = 1'b1;
        WAddr_mem = round_counter;
        KeyIn_mem = extract_key(key_q);
        // The final key is written from the state left by the last round, so no update at 25.
        if (round_counter == 5'(ROUNDS)) begin
          state_d = DONE;
        end else begin
          key_d           = key_round;
          round_counter_d = round_counter + 5'd1;
          rc_d            = rc_next(rc_q);
        end
      end
      DONE: begin
        // Wait for Enable to drop so one assertion yields exactly one schedule.
        if (!Enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rectangle128_skeygen.sv
module tb_rectangle128_skeygen;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        Enable = 1'b0;
  logic [63:0] key0 = 64'd0;
  logic [63:0] key1 = 64'd0;
  logic        flush_mem;
  logic        WE_mem;
  logic [4:0]  WAddr_mem;
  logic [63:0] KeyIn_mem;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_keys [26];
  logic [63:0] got_keys [26];

  localparam logic [3:0] SB [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                                      4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};
  localparam logic [4:0] RCT [25] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16,
                                      5'h0C, 5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C,
                                      5'h18, 5'h11, 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E,
                                      5'h1D};

  localparam logic [63:0] KEY_A = 64'hAABB09182736CCDD;
  localparam logic [63:0] KEY_B = 64'h0123456789ABCDEF;
  localparam logic [63:0] KEY_C = 64'hFEDCBA9876543210;
  localparam logic [63:0] KEY_D = 64'hDEADBEEFCAFEF00D;

  rectangle128_skeygen dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .Enable    (Enable),
    .key0      (key0),
    .key1      (key1),
    .flush_mem (flush_mem),
    .WE_mem    (WE_mem),
    .WAddr_mem (WAddr_mem),
    .KeyIn_mem (KeyIn_mem)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Independent reference of the key schedule, row-by-row with a tabulated RC sequence.
  task automatic build_model(input logic [63:0] k0, input logic [63:0] k1);
    logic [31:0] r0, r1, r2, r3, t0, t2;
    logic [3:0]  x, y;
    r0 = k0[31:0];
    r1 = k0[63:32];
    r2 = k1[31:0];
    r3 = k1[63:32];
    for (int i = 0; i < 26; i++) begin
      exp_keys[i] = {r3[15:0], r2[15:0], r1[15:0], r0[15:0]};
      if (i < 25) begin
        for (int j = 0; j < 8; j++) begin
          x = {r3[j], r2[j], r1[j], r0[j]};
          y = SB[x];
          r0[j] = y[0];
          r1[j] = y[1];
          r2[j] = y[2];
          r3[j] = y[3];
        end
        t0 = {r0[23:0], r0[31:24]} ^ r1;
        t2 = {r2[15:0], r2[31:16]} ^ r3;
        t0[4:0] = t0[4:0] ^ RCT[i];
        r3 = r0;
        r1 = r2;
        r2 = t2;
        r0 = t0;
      end
    end
  endtask

  // Starts a run from IDLE at a falling edge and checks flush plus all 26 writes.
  task automatic do_run(input string name, input logic [63:0] k0, input logic [63:0] k1,
                        input int drop_at, input bit swap_key);
    build_model(k0, k1);
    key0   = k0;
    key1   = k1;
    Enable = 1'b1;
    @(negedge Clk);
    chk($sformatf("%s.flush", name), 64'(flush_mem), 64'd1);
    chk($sformatf("%s.flush_we", name), 64'(WE_mem), 64'd0);
    for (int i = 0; i < 26; i++) begin
      @(negedge Clk);
      got_keys[i] = KeyIn_mem;
      chk($sformatf("%s.we%0d", name, i), 64'(WE_mem), 64'd1);
      chk($sformatf("%s.addr%0d", name, i), 64'(WAddr_mem), 64'(i));
      chk($sformatf("%s.key%0d", name, i), KeyIn_mem, exp_keys[i]);
      chk($sformatf("%s.nofl%0d", name, i), 64'(flush_mem), 64'd0);
      if (i == drop_at) Enable = 1'b0;
      if (swap_key && i == 3) begin
        key0 = KEY_D;
        key1 = ~k1;
      end
    end
    @(negedge Clk);
    chk($sformatf("%s.done_we", name), 64'(WE_mem), 64'd0);
    chk($sformatf("%s.done_flush", name), 64'(flush_mem), 64'd0);
  endtask

  initial begin
    // Reset held with Enable high: nothing may start.
    key0   = KEY_A;
    key1   = KEY_A;
    Enable = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst.flush", 64'(flush_mem), 64'd0);
    chk("rst.we", 64'(WE_mem), 64'd0);
    chk("rst.addr", 64'(WAddr_mem), 64'd0);
    chk("rst.data", KeyIn_mem, 64'd0);
    chk("rst.cnt", 64'(dut.round_counter), 64'd0);

    Enable = 1'b0;
    RstN   = 1'b1;
    @(negedge Clk);
    chk("idle.flush", 64'(flush_mem), 64'd0);
    chk("idle.we", 64'(WE_mem), 64'd0);

    // Spec vector: both halves equal.
    do_run("aabb", KEY_A, KEY_A, -1, 1'b0);
    chk("aabb.k0const", got_keys[0], 64'h0918CCDD0918CCDD);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk($sformatf("hold.we%0d", i), 64'(WE_mem), 64'd0);
      chk($sformatf("hold.flush%0d", i), 64'(flush_mem), 64'd0);
    end

    // All-zero key.
    Enable = 1'b0;
    @(negedge Clk);
    do_run("zero", 64'd0, 64'd0, -1, 1'b0);
    chk("zero.k0const", got_keys[0], 64'd0);
    chk("zero.k1const", got_keys[1], 64'h0000000000FF00FE);

    // Enable dropped after the fifth write, then a fresh run.
    Enable = 1'b0;
    @(negedge Clk);
    do_run("drop", KEY_B, KEY_C, 4, 1'b0);
    @(negedge Clk);
    do_run("rerun", KEY_C, KEY_B, -1, 1'b0);

    // Reset pulse while writing address 10.
    Enable = 1'b0;
    @(negedge Clk);
    key0   = KEY_D;
    key1   = KEY_B;
    Enable = 1'b1;
    @(negedge Clk);
    repeat (11) @(negedge Clk);
    chk("mid.addr", 64'(WAddr_mem), 64'd10);
    chk("mid.we", 64'(WE_mem), 64'd1);
    #1 RstN = 1'b0;
    #1;
    chk("kill.we", 64'(WE_mem), 64'd0);
    chk("kill.addr", 64'(WAddr_mem), 64'd0);
    chk("kill.data", KeyIn_mem, 64'd0);
    chk("kill.cnt", 64'(dut.round_counter), 64'd0);
    @(negedge Clk);
    Enable = 1'b0;
    RstN   = 1'b1;
    @(negedge Clk);
    chk("post.we", 64'(WE_mem), 64'd0);
    chk("post.flush", 64'(flush_mem), 64'd0);
    do_run("after_rst", KEY_D, KEY_B, -1, 1'b0);

    // Inputs changed mid-generation must not disturb the latched key.
    Enable = 1'b0;
    @(negedge Clk);
    do_run("keychg", KEY_B, KEY_D, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
